// File: rtl/ram_fifo_pkg.sv
// Shared sizing and FSM state type for the RAM-backed FIFO controller.
package ram_fifo_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR     = 2'd1,
    ST_RD     = 2'd2,
    ST_RD_CAP = 2'd3
  } state_t;
endpackage

// File: rtl/ram_fifo_ctrl.sv
// 16x16 FIFO controller over an external single-port RAM; one request in flight.
// Push takes one WR cycle; pop returns rd_data/rd_valid three edges after acceptance.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic              ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              err_ovf,
  output logic              err_udf,
  output logic              ram_cs,
  output logic              ram_w_en,
  output logic              ram_op_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_err_ovf;
  logic                r_err_udf;
  logic                r_ram_cs;
  logic                r_ram_w_en;
  logic                r_ram_op_en;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_data_in;
  logic                r_cap_wait;

  logic w_idle;
  logic w_full;
  logic w_empty;
  logic w_pop_acc;
  logic w_push_acc;
  logic w_ovf;
  logic w_udf;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  // Pop wins over push; a rejected pop does not block a push in the same cycle.
  assign w_pop_acc  = w_idle && rd_req && !w_empty;
  assign w_push_acc = w_idle && wr_req && !w_pop_acc && !w_full;
  assign w_ovf      = w_idle && wr_req && !w_pop_acc && w_full;
  assign w_udf      = w_idle && rd_req && w_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_err_udf     <= 1'b0;
      r_ram_cs      <= 1'b0;
      r_ram_w_en    <= 1'b0;
      r_ram_op_en   <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
      r_cap_wait    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_err_ovf  <= w_ovf;
      r_err_udf  <= w_udf;
      case (r_state)
        ST_IDLE: begin
          if (w_pop_acc) begin
            r_state     <= ST_RD;
            r_ram_cs    <= 1'b1;
            r_ram_op_en <= 1'b1;
            r_ram_addr  <= r_rd_ptr;
          end else if (w_push_acc) begin
            r_state       <= ST_WR;
            r_ram_cs      <= 1'b1;
            r_ram_w_en    <= 1'b1;
            r_ram_addr    <= r_wr_ptr;
            r_ram_data_in <= wr_data;
          end
        end
        ST_WR: begin
          r_state       <= ST_IDLE;
          r_wr_ptr      <= r_wr_ptr + 1'b1;
          r_count       <= r_count + 1'b1;
          r_ram_cs      <= 1'b0;
          r_ram_w_en    <= 1'b0;
          r_ram_addr    <= '0;
          r_ram_data_in <= '0;
        end
        ST_RD: begin
          r_state     <= ST_RD_CAP;
          r_rd_ptr    <= r_rd_ptr + 1'b1;
          r_count     <= r_count - 1'b1;
          r_ram_op_en <= 1'b0;
        end
        ST_RD_CAP: begin
          // chip select stays high so the RAM keeps its read register; capture on the second cycle
          if (!r_cap_wait) begin
            r_cap_wait <= 1'b1;
          end else begin
            r_cap_wait <= 1'b0;
            r_state    <= ST_IDLE;
            r_rd_data  <= ram_data_out;
            r_rd_valid <= 1'b1;
            r_ram_cs   <= 1'b0;
            r_ram_addr <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready       = w_idle;
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign err_ovf     = r_err_ovf;
  assign err_udf     = r_err_udf;
  assign ram_cs      = r_ram_cs;
  assign ram_w_en    = r_ram_w_en;
  assign ram_op_en   = r_ram_op_en;
  assign ram_addr    = r_ram_addr;
  assign ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 16x16 RAM and a queue-based FIFO model.
module tb_ram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        wr_req = 1'b0;
  logic        rd_req = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic        ready, rd_valid, full, empty, err_ovf, err_udf;
  logic [15:0] rd_data;
  logic [4:0]  count;
  logic        ram_cs, ram_w_en, ram_op_en;
  logic [3:0]  ram_addr;
  logic [15:0] ram_data_in, ram_data_out;

  ram_fifo_ctrl dut (
    .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .ready(ready), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .err_ovf(err_ovf), .err_udf(err_udf), .ram_cs(ram_cs),
    .ram_w_en(ram_w_en), .ram_op_en(ram_op_en), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data, cleared while deselected.
  logic [15:0] mem [16];
  logic [15:0] ram_q = 16'h0;
  assign ram_data_out = ram_q;
  always @(posedge clk) begin
    if (ram_cs && ram_w_en) mem[ram_addr] <= ram_data_in;
    if (ram_cs && ram_op_en) ram_q <= mem[ram_addr];
    else if (!ram_cs) ram_q <= 16'h0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t        rd_q[$];
  int          ovf_q[$];
  int          udf_q[$];
  logic [15:0] mq[$];
  exp_t        mon_e;
  int          mon_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_valid) begin
        if (rd_q.size() == 0) chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        else begin
          mon_e = rd_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(mon_e.d));
          chk("rd_valid_cycle", 32'(cyc), 32'(mon_e.c));
        end
      end
      if (err_ovf) begin
        if (ovf_q.size() == 0) chk("unexpected_err_ovf", 32'(err_ovf), 32'd0);
        else begin
          mon_c = ovf_q.pop_front();
          chk("err_ovf_cycle", 32'(cyc), 32'(mon_c));
        end
      end
      if (err_udf) begin
        if (udf_q.size() == 0) chk("unexpected_err_udf", 32'(err_udf), 32'd0);
        else begin
          mon_c = udf_q.pop_front();
          chk("err_udf_cycle", 32'(cyc), 32'(mon_c));
        end
      end
      if (ready) chk("idle_ram_strobes", {29'd0, ram_cs, ram_w_en, ram_op_en}, 32'd0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic chk_level(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_full"},  32'(full),  32'(mq.size() == 16));
    chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
  endtask

  // Issue one request pair; the model decides acceptance from its own occupancy.
  task automatic op(input bit w, input bit r, input logic [15:0] d);
    exp_t e;
    wait_ready();
    @(negedge clk);
    wr_req = w; rd_req = r; wr_data = d;
    @(posedge clk); #1;
    if (r) begin
      if (mq.size() > 0) begin
        e.d = mq.pop_front();
        e.c = cyc + 3;
        rd_q.push_back(e);
        rd_req = 1'b0;
        if (w) begin
          wait_ready();
          @(posedge clk); #1;
        end
      end else begin
        udf_q.push_back(cyc);
        rd_req = 1'b0;
      end
    end
    if (w) begin
      if (mq.size() < 16) mq.push_back(d);
      else ovf_q.push_back(cyc);
      wr_req = 1'b0;
    end
    wait_ready();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"},  32'(rd_data),  32'd0);
    chk({tag, "_count"},    32'(count),    32'd0);
    chk({tag, "_empty"},    32'(empty),    32'd1);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_ready"},    32'(ready),    32'd1);
    chk({tag, "_ram"}, {27'd0, ram_cs, ram_w_en, ram_op_en, err_ovf, err_udf}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   cs_seen;
    #2 reset_n = 1'b0;
    #1 chk_reset_state("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Two pushes, two pops with count tracking.
    op(1, 0, 16'hA5A5); chk_level("p1");
    op(1, 0, 16'h1234); chk_level("p2");
    op(0, 1, 16'h0);    chk_level("q1");
    op(0, 1, 16'h0);    chk_level("q2");

    // Fill, overflow, drain.
    for (int i = 0; i < 16; i++) op(1, 0, 16'(i));
    chk_level("filled");
    op(1, 0, 16'hFFFF); chk_level("ovf");
    for (int i = 0; i < 16; i++) op(0, 1, 16'h0);
    chk_level("drained");

    // Underflow: no RAM select may appear.
    cs_seen = 0;
    fork
      begin
        op(0, 1, 16'h0);
        repeat (4) @(posedge clk);
      end
      begin
        repeat (6) begin
          @(negedge clk);
          if (ram_cs) cs_seen++;
        end
      end
    join
    chk("udf_ram_cs_seen", 32'(cs_seen), 32'd0);
    chk_level("udf");

    // Pointer wrap with interleaved pairs.
    for (int i = 0; i < 20; i++) begin
      op(1, 0, 16'(i));
      op(0, 1, 16'h0);
    end
    chk_level("wrap");

    // Simultaneous requests at count 3: pop first, push next.
    for (int i = 0; i < 3; i++) op(1, 0, 16'h0100 + 16'(i));
    op(1, 1, 16'h0ABC); chk_level("both");
    op(1, 1, 16'h0DEF); chk_level("both_empty_check");
    while (mq.size() > 0) op(0, 1, 16'h0);

    // Pop against empty with a push alongside.
    op(1, 1, 16'h7777); chk_level("udf_push");
    op(0, 1, 16'h0);

    // Reset while a pop sits in RD_CAP.
    op(1, 0, 16'h1111);
    op(1, 0, 16'h2222);
    wait_ready();
    @(negedge clk); rd_req = 1'b1;
    @(posedge clk); #1; rd_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1 chk_reset_state("abort");
    mq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    op(1, 0, 16'hBEEF); chk_level("beef_push");
    op(0, 1, 16'h0);    chk_level("beef_pop");

    // Random traffic: write-biased then read-biased.
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 150; n++) begin
        bit w, r;
        w = ($urandom_range(0, 9) < (ph == 0 ? 7 : 3));
        r = ($urandom_range(0, 9) < (ph == 0 ? 3 : 7));
        if (w || r) op(w, r, 16'($urandom));
      end
      chk_level("random");
    end

    repeat (6) @(negedge clk);
    chk("pending_rd", 32'(rd_q.size()), 32'd0);
    chk("pending_ovf", 32'(ovf_q.size()), 32'd0);
    chk("pending_udf", 32'(udf_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
